unpacked_array_serializer: RTL and testbench
============================================

Name: unpacked_array_serializer

Overview:
- Reads out an unpacked array of count words, one element per handshake, on a valid/ready stream.
- It is the consumer-side counterpart of blocks that build unpacked arrays by concatenation or replication, for example a two-entry array of 16-bit counts.
- Used in regression designs to check that unpacked-array contents survive capture and serial readout in order.

Parameters:
- NUM_ELEM, 2: number of array elements; must be >= 1.
- ELEM_W, 16: element width in bits; default equals $bits(count_t).
- LSB_FIRST, 1: 1 sends element [0] first and ascends; 0 sends element [NUM_ELEM-1] first and descends.

Ports:
- clk  input  1  single clock; all logic on its rising edge.
- rst  input  1  reset, synchronous, active-high.
- in_valid  input  1  array offered on in_data.
- in_ready  output  1  block can capture an array this cycle.
- in_data  input  ELEM_W x [NUM_ELEM-1:0] unpacked  array to serialize.
- out_valid  output  1  out_data holds a valid element.
- out_ready  input  1  downstream accepts the element.
- out_data  output  ELEM_W  current element.
- out_idx  output  IDX_W  array index of the current element; IDX_W = (NUM_ELEM>1) ? $clog2(NUM_ELEM) : 1.
- out_last  output  1  current element is the final one of the array.
- frames_done  output  32 (bit_int_t)  count of fully sent arrays.

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset, sampled at the clk edge:
  - state=IDLE, out_valid=0, out_idx=start index, out_last=(NUM_ELEM==1), frames_done=0.
  - Shadow array contents are don't-care.
  - While rst is high, in_ready=0.
- Start index is 0 when LSB_FIRST=1, else NUM_ELEM-1. End index is the opposite extreme.
- State IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid&&in_ready, capture all of in_data into the shadow array, set the index to start, and go to SEND.
  - out_valid rises the next cycle, giving 1-cycle capture-to-first-element latency.
- State SEND:
  - out_valid=1, out_data=shadow[idx], out_idx=idx, out_last=(idx==end).
- Beat handshake: out_valid&&out_ready.
  - Not last: step idx by +1 (LSB_FIRST) or -1; stay in SEND.
  - Last: increment frames_done. If in_valid is high the same cycle, capture the new array and stay in SEND with idx=start (back-to-back, no bubble). Otherwise go to IDLE.
- in_ready = !rst && (state==IDLE || (state==SEND && out_last && out_ready)). This is a combinational path from out_ready to in_ready and is intentional.
- Stability: while out_valid && !out_ready, out_data, out_idx and out_last hold. The shadow array is not overwritten while in SEND except on the last beat.
- NUM_ELEM=1: every beat is last, out_idx stays 0, and each captured array produces exactly one beat.
- frames_done wraps from 32'hFFFF_FFFF to 0 with no saturation.
- Reset mid-operation: the in-flight array is discarded, out_valid drops on the cycle after rst is sampled, and frames_done clears.
- in_data is sampled only on a capture handshake; changes at any other time have no effect.

Decomposition:
- Package unpacked_ser_pkg holds:
  - typedef logic [15:0] count_t;
  - typedef bit [31:0] bit_int_t;
  - localparam int COUNT_BITS = $bits(count_t);
  - state enum {IDLE, SEND}.
- No sub-module. The shadow array, index counter and frame counter fit directly in one module.

Test Plan:
- NUM_ELEM=2, LSB_FIRST=1, in_data={16,16} (built by {2{16}}), out_ready=1 → beats (idx0,16,last=0), (idx1,16,last=1); frames_done=1; first out_valid 1 cycle after capture.
- NUM_ELEM=4, LSB_FIRST=0, in_data[i]=i+1 → data order 4,3,2,1, idx order 3,2,1,0, out_last only on idx 0.
- Backpressure: out_ready low for 3 cycles on beat 0 → out_data, out_idx and out_last stay constant; no beat is lost or duplicated; total 2 beats.
- Back-to-back: second array {16'hAAAA,16'h5555} presented with in_valid held during the last beat of the first → in_ready=1 that cycle, no idle cycle, frames_done=2 after 4 beats.
- Reset after beat 0 of a 4-element array → out_valid=0 the next cycle, frames_done=0, in_ready=1 once rst deasserts; a new array then sends from the start index.
- NUM_ELEM=1 → every beat has out_last=1 and out_idx=0. frames_done is force-preset to 32'hFFFF_FFFF (bench hierarchical deposit), then one more frame is sent → frames_done wraps to 0.

Source files
------------

// File: rtl/unpacked_ser_pkg.sv
// Shared types for the unpacked-array serializer: element/count types and FSM states.
package unpacked_ser_pkg;

  typedef logic [15:0] count_t;
  typedef bit [31:0] bit_int_t;

  localparam int COUNT_BITS = $bits(count_t);

  typedef enum logic {IDLE, SEND} state_t;

endpackage

// File: rtl/unpacked_array_serializer.sv
// Captures an unpacked array in one handshake and streams it out one element per beat,
// ascending or descending, with back-to-back capture on the final beat.
module unpacked_array_serializer
  import unpacked_ser_pkg::*;
#(
  parameter int unsigned NUM_ELEM  = 2,
  parameter int unsigned ELEM_W    = COUNT_BITS,
  parameter bit          LSB_FIRST = 1'b1,
  localparam int unsigned IDX_W    = (NUM_ELEM > 1) ? $clog2(NUM_ELEM) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ELEM_W-1:0] in_data [NUM_ELEM-1:0],
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ELEM_W-1:0] out_data,
  output logic [IDX_W-1:0]  out_idx,
  output logic              out_last,
  output bit_int_t          frames_done
);

  localparam logic [IDX_W-1:0] START_IDX = LSB_FIRST ? '0 : IDX_W'(NUM_ELEM - 1);
  localparam logic [IDX_W-1:0] END_IDX   = LSB_FIRST ? IDX_W'(NUM_ELEM - 1) : '0;

  state_t            state;
  state_t            state_d;
  logic [IDX_W-1:0]  idx_d;
  logic [ELEM_W-1:0] out_data_d;
  logic [ELEM_W-1:0] shadow [NUM_ELEM-1:0];
  logic              capture;
  logic              beat;
  logic              last_beat;

  // in_ready depends combinationally on out_ready so the next array can enter on the last beat.
  assign in_ready  = !rst && ((state == IDLE) || ((state == SEND) && out_last && out_ready));
  assign capture   = in_valid && in_ready;
  assign beat      = out_valid && out_ready;
  assign last_beat = beat && out_last;

  // Next-state, next-index and next-element selection.
  always_comb begin
    state_d    = state;
    idx_d      = out_idx;
    out_data_d = out_data;
    case (state)
      IDLE: begin
        if (capture) begin
          state_d = SEND;
          idx_d   = START_IDX;
        end
      end
      SEND: begin
        if (beat) begin
          if (!out_last) begin
            idx_d = LSB_FIRST ? out_idx + IDX_W'(1) : out_idx - IDX_W'(1);
          end else if (capture) begin
            idx_d = START_IDX;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    out_data_d = capture ? in_data[START_IDX] : shadow[idx_d];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      out_valid   <= 1'b0;
      out_idx     <= START_IDX;
      out_last    <= (NUM_ELEM == 1);
      out_data    <= '0;
      frames_done <= '0;
    end else begin
      state     <= state_d;
      out_valid <= (state_d == SEND);
      out_idx   <= idx_d;
      out_last  <= (idx_d == END_IDX);
      out_data  <= out_data_d;
      if (last_beat) begin
        frames_done <= frames_done + 32'd1;
      end
    end
  end

  // Shadow copy is only written on a capture handshake; contents after reset are don't-care.
  always_ff @(posedge clk) begin
    if (capture) begin
      shadow <= in_data;
    end
  end

endmodule

// File: tb/tb_unpacked_array_serializer.sv
// Bench for unpacked_array_serializer: cycle table (2 elem, ascending), queue model with
// random stimulus (4 elem, descending) and a hand sequence for the single-element case.
module tb_unpacked_array_serializer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_pass = 0;
  int unsigned n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Instance A: 2 elements, ascending
  logic        a_rst, a_iv, a_in_ready, a_out_valid, a_or, a_out_last;
  logic [15:0] a_data [1:0];
  logic [15:0] a_out_data;
  logic [0:0]  a_out_idx;
  logic [31:0] a_frames;

  unpacked_array_serializer #(.NUM_ELEM(2), .ELEM_W(16), .LSB_FIRST(1'b1)) u_a (
    .clk(clk), .rst(a_rst), .in_valid(a_iv), .in_ready(a_in_ready), .in_data(a_data),
    .out_valid(a_out_valid), .out_ready(a_or), .out_data(a_out_data), .out_idx(a_out_idx),
    .out_last(a_out_last), .frames_done(a_frames)
  );

  // Instance B: 4 elements, descending
  logic        b_rst, b_iv, b_in_ready, b_out_valid, b_or, b_out_last;
  logic [15:0] b_data [3:0];
  logic [15:0] b_out_data;
  logic [1:0]  b_out_idx;
  logic [31:0] b_frames;

  unpacked_array_serializer #(.NUM_ELEM(4), .ELEM_W(16), .LSB_FIRST(1'b0)) u_b (
    .clk(clk), .rst(b_rst), .in_valid(b_iv), .in_ready(b_in_ready), .in_data(b_data),
    .out_valid(b_out_valid), .out_ready(b_or), .out_data(b_out_data), .out_idx(b_out_idx),
    .out_last(b_out_last), .frames_done(b_frames)
  );

  // Instance C: single element
  logic        c_rst, c_iv, c_in_ready, c_out_valid, c_or, c_out_last;
  logic [15:0] c_data [0:0];
  logic [15:0] c_out_data;
  logic [0:0]  c_out_idx;
  logic [31:0] c_frames;

  unpacked_array_serializer #(.NUM_ELEM(1), .ELEM_W(16), .LSB_FIRST(1'b1)) u_c (
    .clk(clk), .rst(c_rst), .in_valid(c_iv), .in_ready(c_in_ready), .in_data(c_data),
    .out_valid(c_out_valid), .out_ready(c_or), .out_data(c_out_data), .out_idx(c_out_idx),
    .out_last(c_out_last), .frames_done(c_frames)
  );

  // Cycle vectors for instance A: inputs this cycle, outputs seen before the next edge.
  typedef struct {
    bit rst; bit iv; logic [15:0] d0; logic [15:0] d1; bit ordy;
    bit e_rdy; bit e_ov; logic [15:0] e_data; bit e_idx; bit e_last; logic [31:0] e_frames;
  } vec_t;

  vec_t vecs [13];

  // Reference for B: pending beats of the current array, in send order.
  typedef struct { logic [15:0] data; logic [1:0] idx; bit last; } beat_t;
  beat_t       bq [$];
  logic [31:0] bframes = 0;

  task automatic step_b(input bit r, input bit iv, input logic [15:0] d [3:0], input bit ordy);
    bit    exp_rdy;
    beat_t e;
    b_rst = r; b_iv = iv; b_data = d; b_or = ordy;
    #3;
    exp_rdy = !r && (bq.size() == 0 || (bq.size() == 1 && ordy));
    check("b in_ready", 32'(b_in_ready), 32'(exp_rdy));
    check("b out_valid", 32'(b_out_valid), 32'(bq.size() != 0));
    if (bq.size() != 0) begin
      e = bq[0];
      check("b out_data", 32'(b_out_data), 32'(e.data));
      check("b out_idx", 32'(b_out_idx), 32'(e.idx));
      check("b out_last", 32'(b_out_last), 32'(e.last));
    end
    check("b frames_done", b_frames, bframes);
    if (r) begin
      bq.delete();
      bframes = 0;
    end else begin
      if (bq.size() != 0 && ordy) begin
        if (bq.size() == 1) bframes++;
        void'(bq.pop_front());
      end
      if (iv && exp_rdy) begin
        for (int k = 0; k < 4; k++) begin
          e.idx  = 2'(3 - k);
          e.data = d[3 - k];
          e.last = (k == 3);
          bq.push_back(e);
        end
      end
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [15:0] d [3:0];

    vecs[0]  = '{1, 0, 16'h0000, 16'h0000, 1, 0, 0, 16'h0000, 0, 0, 0};
    vecs[1]  = '{0, 1, 16'd16,   16'd16,   1, 1, 0, 16'h0000, 0, 0, 0};
    vecs[2]  = '{0, 0, 16'h0000, 16'h0000, 1, 0, 1, 16'd16,   0, 0, 0};
    vecs[3]  = '{0, 0, 16'h0000, 16'h0000, 1, 1, 1, 16'd16,   1, 1, 0};
    vecs[4]  = '{0, 1, 16'h1111, 16'h2222, 1, 1, 0, 16'h0000, 0, 0, 1};
    vecs[5]  = '{0, 0, 16'h0000, 16'h0000, 0, 0, 1, 16'h1111, 0, 0, 1};
    vecs[6]  = '{0, 1, 16'hDEAD, 16'hBEEF, 0, 0, 1, 16'h1111, 0, 0, 1};
    vecs[7]  = '{0, 0, 16'h0000, 16'h0000, 0, 0, 1, 16'h1111, 0, 0, 1};
    vecs[8]  = '{0, 0, 16'h0000, 16'h0000, 1, 0, 1, 16'h1111, 0, 0, 1};
    vecs[9]  = '{0, 1, 16'h5555, 16'hAAAA, 1, 1, 1, 16'h2222, 1, 1, 1};
    vecs[10] = '{0, 0, 16'h0000, 16'h0000, 1, 0, 1, 16'h5555, 0, 0, 2};
    vecs[11] = '{0, 0, 16'h0000, 16'h0000, 1, 1, 1, 16'hAAAA, 1, 1, 2};
    vecs[12] = '{0, 0, 16'h0000, 16'h0000, 1, 1, 0, 16'h0000, 0, 0, 3};

    a_rst = 1; a_iv = 0; a_or = 1; a_data[0] = '0; a_data[1] = '0;
    b_rst = 1; b_iv = 0; b_or = 1;
    c_rst = 1; c_iv = 0; c_or = 1; c_data[0] = '0;
    for (int i = 0; i < 4; i++) b_data[i] = '0;
    repeat (2) @(posedge clk);
    #1;

    // Instance A: table-driven
    for (int i = 0; i < 13; i++) begin
      a_rst = vecs[i].rst; a_iv = vecs[i].iv; a_or = vecs[i].ordy;
      a_data[0] = vecs[i].d0; a_data[1] = vecs[i].d1;
      #3;
      check($sformatf("a[%0d] in_ready", i), 32'(a_in_ready), 32'(vecs[i].e_rdy));
      check($sformatf("a[%0d] out_valid", i), 32'(a_out_valid), 32'(vecs[i].e_ov));
      if (vecs[i].e_ov) check($sformatf("a[%0d] out_data", i), 32'(a_out_data), 32'(vecs[i].e_data));
      if (vecs[i].e_ov || vecs[i].rst) begin
        check($sformatf("a[%0d] out_idx", i), 32'(a_out_idx), 32'(vecs[i].e_idx));
        check($sformatf("a[%0d] out_last", i), 32'(a_out_last), 32'(vecs[i].e_last));
      end
      check($sformatf("a[%0d] frames_done", i), a_frames, vecs[i].e_frames);
      @(posedge clk); #1;
    end

    // Instance B: ordering 4,3,2,1 then idle
    for (int i = 0; i < 4; i++) d[i] = 16'(i + 1);
    step_b(1, 0, d, 1);
    step_b(0, 1, d, 1);
    for (int i = 0; i < 5; i++) step_b(0, 0, d, 1);

    // Instance B: reset after beat 0, then a fresh array from the start index
    for (int i = 0; i < 4; i++) d[i] = 16'hC000 + 16'(i);
    step_b(0, 1, d, 1);
    step_b(0, 0, d, 1);
    step_b(1, 0, d, 1);
    step_b(0, 0, d, 1);
    for (int i = 0; i < 4; i++) d[i] = 16'hE000 + 16'(i);
    step_b(0, 1, d, 1);
    for (int i = 0; i < 5; i++) step_b(0, 0, d, 1);

    // Instance B: random stimulus against the queue model
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 4; i++) d[i] = 16'($urandom);
      step_b($urandom_range(0, 99) == 0, 1'($urandom_range(0, 1)), d, $urandom_range(0, 3) != 0);
    end

    // Instance C: single element, back-to-back, counter wrap
    c_rst = 0; c_iv = 0; c_or = 1;
    #3;
    check("c reset out_valid", 32'(c_out_valid), 32'd0);
    check("c reset out_idx", 32'(c_out_idx), 32'd0);
    check("c reset out_last", 32'(c_out_last), 32'd1);
    check("c reset in_ready", 32'(c_in_ready), 32'd1);
    check("c reset frames_done", c_frames, 32'd0);
    @(posedge clk); #1;
    c_iv = 1; c_data[0] = 16'h1234;
    #3;
    check("c idle in_ready", 32'(c_in_ready), 32'd1);
    @(posedge clk); #1;
    c_iv = 1; c_data[0] = 16'h5678;
    #3;
    check("c beat1 out_valid", 32'(c_out_valid), 32'd1);
    check("c beat1 out_data", 32'(c_out_data), 32'h1234);
    check("c beat1 out_idx", 32'(c_out_idx), 32'd0);
    check("c beat1 out_last", 32'(c_out_last), 32'd1);
    check("c beat1 in_ready", 32'(c_in_ready), 32'd1);
    @(posedge clk); #1;
    c_iv = 0;
    #3;
    check("c beat2 out_valid", 32'(c_out_valid), 32'd1);
    check("c beat2 out_data", 32'(c_out_data), 32'h5678);
    check("c beat2 out_idx", 32'(c_out_idx), 32'd0);
    check("c beat2 out_last", 32'(c_out_last), 32'd1);
    check("c beat2 frames_done", c_frames, 32'd1);
    @(posedge clk); #1;
    #3;
    check("c idle out_valid", 32'(c_out_valid), 32'd0);
    check("c idle frames_done", c_frames, 32'd2);
    force u_c.frames_done = 32'hFFFF_FFFF;
    #1;
    release u_c.frames_done;
    @(posedge clk); #1;
    c_iv = 1; c_data[0] = 16'h9ABC;
    #3;
    check("c preset frames_done", c_frames, 32'hFFFF_FFFF);
    @(posedge clk); #1;
    c_iv = 0;
    #3;
    check("c wrap beat out_data", 32'(c_out_data), 32'h9ABC);
    check("c wrap beat out_last", 32'(c_out_last), 32'd1);
    @(posedge clk); #1;
    #3;
    check("c wrap frames_done", c_frames, 32'd0);
    check("c wrap out_valid", 32'(c_out_valid), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
